serial_alu_sequencer: RTL and testbench

Bit-serial N-bit ALU built around one instance of the existing 1-bit ALU, which supports AND, OR and ADD with carry-in and carry-out. The sequencer latches two WIDTH-bit operands and feeds the 1-bit ALU one bit pair per clock, LSB first. It drives the ALU's Operation code and registers CarryOut back into CarryIn. It also implements SUB by inverting b and seeding the carry. It sits between a simple start/done requester and the combinational 1-bit ALU.

---
 rtl/serial_alu_pkg.sv | 37 +++
 rtl/serial_alu_sequencer_one_bit_alu.sv | 29 ++
 rtl/serial_alu_sequencer.sv | 125 ++++++++++++
 tb/tb_serial_alu_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared types and 1-bit ALU operation codes for the bit-serial ALU.
// Optional signed-overflow output is enabled with SERIAL_ALU_OVF_EN.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ALU_OP_AND = 2'd0;
    localparam logic [1:0] ALU_OP_OR  = 2'd1;
    localparam logic [1:0] ALU_OP_ADD = 2'd2;

    // SUB runs through the adder, so code 3 is never produced.
    function automatic logic [1:0] alu_code(op_e op);
        logic [1:0] code;
        case (op)
            OP_AND:  code = ALU_OP_AND;
            OP_OR:   code = ALU_OP_OR;
            default: code = ALU_OP_ADD;
        endcase
        return code;
    endfunction

    function automatic logic is_arith(op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_sequencer_one_bit_alu.sv
// Combinational 1-bit ALU: AND, OR and full-adder ADD.
// Operation code 3 yields a zero result.
module one_bit_ALU
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       CarryIn,
    input  logic [1:0] Operation,
    output logic       Result,
    output logic       CarryOut
);

    logic sum;

    assign sum      = a ^ b ^ CarryIn;
    assign CarryOut = (a & b) | (a & CarryIn) | (b & CarryIn);

    always_comb begin
        Result = 1'b0;
        case (Operation)
            ALU_OP_AND: Result = a & b;
            ALU_OP_OR:  Result = a | b;
            ALU_OP_ADD: Result = sum;
            default:    Result = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial WIDTH-bit ALU sequencing one 1-bit ALU, LSB first.
// Define SERIAL_ALU_OVF_EN to add the registered signed overflow output.
module serial_alu_sequencer
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q;
    op_e              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_sr_q;
    logic [WIDTH-1:0] res_sr_d;
    logic [WIDTH-1:0] result_q;
    logic             cy_q;
    logic             cy_d;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             last;
    logic             b_bit;
    logic             alu_res;
    logic             alu_cout;
`ifdef SERIAL_ALU_OVF_EN
    logic             ovf_q;
`endif

    assign b_bit = b_sr_q[0] ^ (op_q == OP_SUB);

    one_bit_ALU u_alu (
        .a         (a_sr_q[0]),
        .b         (b_bit),
        .CarryIn   (cy_q),
        .Operation (alu_code(op_q)),
        .Result    (alu_res),
        .CarryOut  (alu_cout)
    );

    assign res_sr_d = {alu_res, res_sr_q[WIDTH-1:1]};
    assign cy_d     = is_arith(op_q) ? alu_cout : 1'b0;
    assign last     = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_AND;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            result_q <= '0;
            cy_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        op_q    <= op_e'(op);
                        cnt_q   <= '0;
                        cy_q    <= (op_e'(op) == OP_SUB);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_sr_q <= res_sr_d;
                    cy_q     <= cy_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= res_sr_d;
                        cout_q   <= cy_d;
`ifdef SERIAL_ALU_OVF_EN
                        // cy_q holds the carry into the MSB here
                        ovf_q    <= is_arith(op_q) & (cy_q ^ alu_cout);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = cout_q;
`ifdef SERIAL_ALU_OVF_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboard bench for serial_alu_sequencer (WIDTH = 8).
// Overflow is checked only when SERIAL_ALU_OVF_EN is defined.
module tb_serial_alu_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
`ifdef SERIAL_ALU_OVF_EN
    logic         overflow;
`endif

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
`ifdef SERIAL_ALU_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         cy;
        logic         ov;
        int           t0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pushed = 0;
    int   dones = 0;
    int   busy_cnt = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive a request; caller is away from the edge. t0 is the start edge.
    task automatic issue(string nm, logic [1:0] o, logic [W-1:0] x,
                         logic [W-1:0] y, logic [W-1:0] r, logic c,
                         logic v, bit track);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            e.name = nm;
            e.res  = r;
            e.cy   = c;
            e.ov   = v;
            e.t0   = cyc;
            sb.push_back(e);
            pushed++;
        end
    endtask

    task automatic drain(string nm);
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0",
                     nm, sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                dones++;
                chk("done_one_cycle", 32'(prev_done), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, 32'(result), 32'(e.res));
                    chk({e.name, "_carry"}, 32'(carry_out), 32'(e.cy));
`ifdef SERIAL_ALU_OVF_EN
                    chk({e.name, "_ovf"}, 32'(overflow), 32'(e.ov));
`endif
                    chk({e.name, "_latency"}, 32'(cyc - e.t0), W);
                    chk({e.name, "_busy_cycles"}, 32'(busy_cnt), W);
                    chk({e.name, "_busy_low"}, 32'(busy), 0);
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_carry", 32'(carry_out), 0);
`ifdef SERIAL_ALU_OVF_EN
        chk("rst_ovf", 32'(overflow), 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        issue("add_ff_01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1);
        drain("add_ff_01");
        @(negedge clk);
        issue("sub_05_07", 2'b11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1);
        drain("sub_05_07");
        @(negedge clk);
        issue("sub_80_01", 2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1);
        drain("sub_80_01");
        @(negedge clk);
        issue("and_f0_3c", 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1);
        drain("and_f0_3c");

        // start during the third RUN cycle must be ignored
        @(negedge clk);
        issue("add_12_34", 2'b10, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        issue("ignored", 2'b10, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 0);
        drain("add_12_34");
        repeat (3) @(negedge clk);
        chk("no_second_op_busy", 32'(busy), 0);

        // reset during the fourth RUN cycle aborts without done
        @(negedge clk);
        issue("aborted", 2'b10, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_carry", 32'(carry_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue("add_7f_01", 2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1);
        drain("add_7f_01");

        // back-to-back: second start issued in the DONE cycle
        @(negedge clk);
        issue("or_f0_3c", 2'b01, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1);
        drain("or_f0_3c");
        issue("or_0f_f0", 2'b01, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1);
        drain("or_0f_f0");

        repeat (12) @(negedge clk);
        chk("done_count", 32'(dones), 32'(pushed));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
